wb_stage: RTL

- Writeback end of the register-file write port that the decode stage reads from.
- Latches the MEM/WB bundle and selects the destination register (RegDst) and write data (RegSrc).
- Drives a one-cycle registered regfile write: write_en / write_reg / write_data.
- Holds a per-register pending-write scoreboard: decode reports each issued writer, wb_stage reports busy registers back to decode's hazard/stall logic, and exposes a bypass copy of the current write.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_scoreboard.sv | 59 +++++
 rtl/wb_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: RegSrc/RegDst selects and the link register index.
package wb_pkg;

    localparam logic [1:0] SRC_LINK = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_ALU  = 2'b10;
    localparam logic [1:0] SRC_B    = 2'b11;

    localparam logic [1:0] DST_RS   = 2'b00;
    localparam logic [1:0] DST_RT   = 2'b01;
    localparam logic [1:0] DST_RD   = 2'b10;
    localparam logic [1:0] DST_LINK = 2'b11;

    localparam logic [2:0] LINK_REG = 3'd7;

    function automatic logic [2:0] decode_dst(input logic [1:0] regdst, input logic [15:0] instr);
        logic [2:0] dst;
        case (regdst)
            DST_RS:  dst = instr[10:8];
            DST_RT:  dst = instr[7:5];
            DST_RD:  dst = instr[4:2];
            default: dst = LINK_REG;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-writer counters; busy flags and a sticky over/underflow error for decode.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [2:0]      iss_dst,
    input  logic            rel_valid,
    input  logic [2:0]      rel_dst,
    output logic [NREG-1:0] busy,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [NREG-1:0]  ONE_HOT = {{(NREG-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             err_set;

    assign inc_vec = iss_valid ? (ONE_HOT << iss_dst) : '0;
    assign dec_vec = rel_valid ? (ONE_HOT << rel_dst) : '0;

    // Issue and release of the same register cancel; saturate at either end and flag it.
    always_comb begin
        err_set = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt[r] == CNT_MAX) err_set = 1'b1;
                else                   cnt_nxt[r] = cnt[r] + 1'b1;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt[r] == '0) err_set = 1'b1;
                else              cnt_nxt[r] = cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (err_set) err <= 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM/WB bundle into a one-cycle regfile write and tracks pending writers.
module wb_stage
    import wb_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [2:0]      iss_dst,
    input  logic            in_valid,
    input  logic            in_kill,
    input  logic            in_regwrt,
    input  logic [1:0]      in_regdst,
    input  logic [1:0]      in_regsrc,
    input  logic [15:0]     in_instr,
    input  logic [15:0]     in_pc_plus2,
    input  logic [15:0]     in_mem_data,
    input  logic [15:0]     in_alu_out,
    input  logic [15:0]     in_b_val,
    output logic            write_en,
    output logic [2:0]      write_reg,
    output logic [15:0]     write_data,
    output logic [NREG-1:0] busy,
    output logic            fwd_valid,
    output logic [2:0]      fwd_reg,
    output logic [15:0]     fwd_data,
    output logic            err
);

    logic [2:0]  dst_sel;
    logic [15:0] data_sel;
    logic        do_write;
    logic        release_v;

    assign dst_sel = decode_dst(in_regdst, in_instr);

    always_comb begin
        case (in_regsrc)
            SRC_LINK: data_sel = in_pc_plus2;
            SRC_MEM:  data_sel = in_mem_data;
            SRC_ALU:  data_sel = in_alu_out;
            default:  data_sel = in_b_val;
        endcase
    end

    // A killed bundle still frees its scoreboard slot; it just never reaches the regfile.
    assign do_write  = in_valid && !in_kill && in_regwrt;
    assign release_v = in_valid && in_regwrt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            write_en <= do_write;
            if (do_write) begin
                write_reg  <= dst_sel;
                write_data <= data_sel;
            end
        end
    end

    assign fwd_valid = write_en;
    assign fwd_reg   = write_reg;
    assign fwd_data  = write_data;

    wb_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .rel_valid (release_v),
        .rel_dst   (dst_sel),
        .busy      (busy),
        .err       (err)
    );

endmodule
